// File: rtl/minv_mdiv_host.sv
// rtl/minv_mdiv_host.sv - host initiator that loads, starts and unloads the modular inverse/division core
module minv_mdiv_host #(
    parameter int WORDS          = 8,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_mode,
    input  logic [32*WORDS-1:0]   req_a,
    input  logic [32*WORDS-1:0]   req_b,
    input  logic [32*WORDS-1:0]   req_p,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [32*WORDS-1:0]   rsp_result,
    output logic                  rsp_flag,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [31:0]           core_datain,
    output logic                  core_loada,
    output logic                  core_loadp,
    output logic                  core_loadb,
    output logic                  core_minv_mdiv,
    output logic                  core_en,
    input  logic                  core_rdy,
    input  logic                  core_flag,
    input  logic [31:0]           core_result,
    input  logic                  core_out_valid,
    output logic                  core_out_ready
);

    localparam int W  = 32 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_P,
        S_LOAD_B,
        S_START,
        S_WAIT,
        S_COLLECT,
        S_RESP
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   p_q;
    logic           mode_q;
    logic [IW-1:0]  idx;
    logic [TW-1:0]  timer;
    logic [W-1:0]   result_q;
    logic           flag_q;
    logic           timeout_q;
    logic           last_word;
    logic           time_up;

    // The final result word wins over a timeout landing on the same edge.
    assign last_word = core_out_valid && (idx == LAST_IDX);
    assign time_up   = (timer >= T_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and all handshake/strobe outputs, decoded from state.
    always_comb begin
        next_state     = state;
        req_ready      = 1'b0;
        busy           = 1'b1;
        rsp_valid      = 1'b0;
        rsp_result     = '0;
        rsp_flag       = 1'b0;
        rsp_timeout    = 1'b0;
        core_datain    = 32'd0;
        core_loada     = 1'b0;
        core_loadp     = 1'b0;
        core_loadb     = 1'b0;
        core_minv_mdiv = mode_q;
        core_en        = 1'b0;
        core_out_ready = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready      = 1'b1;
                busy           = 1'b0;
                core_minv_mdiv = 1'b0;
                if (req_valid) next_state = S_LOAD_A;
            end
            S_LOAD_A: begin
                core_loada  = 1'b1;
                core_datain = a_q[32*idx +: 32];
                if (idx == LAST_IDX) next_state = S_LOAD_P;
            end
            S_LOAD_P: begin
                core_loadp  = 1'b1;
                core_datain = p_q[32*idx +: 32];
                if (idx == LAST_IDX) next_state = S_LOAD_B;
            end
            S_LOAD_B: begin
                core_loadb  = 1'b1;
                core_datain = b_q[32*idx +: 32];
                if (idx == LAST_IDX) next_state = S_START;
            end
            S_START: begin
                core_en    = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (core_rdy) next_state = S_COLLECT;
                else if (time_up) next_state = S_RESP;
            end
            S_COLLECT: begin
                core_out_ready = 1'b1;
                if (last_word || time_up) next_state = S_RESP;
            end
            S_RESP: begin
                rsp_valid   = 1'b1;
                rsp_result  = result_q;
                rsp_flag    = flag_q;
                rsp_timeout = timeout_q;
                if (rsp_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Job datapath: operand latch, word index, timeout counter and result assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            mode_q    <= 1'b0;
            idx       <= '0;
            timer     <= '0;
            result_q  <= '0;
            flag_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_q       <= req_a;
                        b_q       <= req_b;
                        p_q       <= req_p;
                        mode_q    <= req_mode;
                        idx       <= '0;
                        result_q  <= '0;
                        flag_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                S_LOAD_A, S_LOAD_P, S_LOAD_B: begin
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                S_START: begin
                    timer <= '0;
                end
                S_WAIT: begin
                    if (core_rdy) begin
                        flag_q <= core_flag;
                        timer  <= '0;
                        idx    <= '0;
                    end else if (time_up) begin
                        timeout_q <= 1'b1;
                    end else if (timer != T_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (core_out_valid) begin
                        result_q[32*idx +: 32] <= core_result;
                        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end
                    if (!last_word && time_up) begin
                        timeout_q <= 1'b1;
                    end else if (timer != T_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minv_mdiv_host.sv
// tb/tb_minv_mdiv_host.sv - scoreboard bench for minv_mdiv_host with a behavioural core model
module tb_minv_mdiv_host;

    localparam int WORDS = 8;
    localparam int TMO   = 64;

    localparam logic [255:0] SM2_P = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] SM2_A = 256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;
    localparam logic [255:0] SM2_B = 256'hBC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0;
    localparam logic [255:0] R_SCRIPT = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_mode;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [255:0] req_p;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [255:0] rsp_result;
    logic         rsp_flag;
    logic         rsp_timeout;
    logic         busy;
    logic [31:0]  core_datain;
    logic         core_loada;
    logic         core_loadp;
    logic         core_loadb;
    logic         core_minv_mdiv;
    logic         core_en;
    logic         core_rdy;
    logic         core_flag;
    logic [31:0]  core_result;
    logic         core_out_valid;
    logic         core_out_ready;

    minv_mdiv_host #(.WORDS(WORDS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_a(req_a), .req_b(req_b), .req_p(req_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flag(rsp_flag), .rsp_timeout(rsp_timeout), .busy(busy),
        .core_datain(core_datain), .core_loada(core_loada), .core_loadp(core_loadp),
        .core_loadb(core_loadb), .core_minv_mdiv(core_minv_mdiv), .core_en(core_en),
        .core_rdy(core_rdy), .core_flag(core_flag), .core_result(core_result),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] result;
        logic         flag;
        logic         timeout;
    } rsp_t;

    rsp_t exp_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   rsp_count = 0;
    logic [31:0] seen_data [1:26];

    // core model configuration, written by the stimulus at posedge+1
    bit   cfg_never_rdy = 0;
    bit   cfg_gaps      = 0;
    logic cfg_flag      = 0;
    int   cfg_delay     = 3;
    logic [255:0] cap_a;
    logic [255:0] cap_p;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rsp_t mk(input logic [255:0] r, input logic f, input logic t);
        rsp_t e;
        e.result  = r;
        e.flag    = f;
        e.timeout = t;
        return e;
    endfunction

    // Behavioural core: records loads, computes or scripts a result, handshakes it out.
    initial begin
        logic [255:0] ma, mp, mb, mres;
        int  ka, kp, kb, mstate, mdelay, mj, extra;
        bit  prev_ready, gap3, gap7;
        logic mmode;
        ma = '0; mp = '0; mb = '0; mres = '0;
        ka = 0; kp = 0; kb = 0; mstate = 0; mdelay = 0; mj = 0; extra = 0;
        prev_ready = 0; gap3 = 0; gap7 = 0; mmode = 0;
        core_rdy = 0; core_flag = 0; core_result = '0; core_out_valid = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ka = 0; kp = 0; kb = 0; mstate = 0;
                core_rdy = 0; core_flag = 0; core_result = '0; core_out_valid = 0;
            end else begin
                if (core_loada && ka < WORDS) begin ma[32*ka +: 32] = core_datain; ka++; end
                if (core_loadp && kp < WORDS) begin mp[32*kp +: 32] = core_datain; kp++; end
                if (core_loadb && kb < WORDS) begin mb[32*kb +: 32] = core_datain; kb++; end
                if (mstate == 0 && core_en) begin
                    mmode = core_minv_mdiv;
                    cap_a = ma;
                    cap_p = mp;
                    mres  = '0;
                    if (mmode) begin
                        for (longint x = 1; x < longint'(mp[31:0]) && x < 4096; x++)
                            if ((longint'(ma[31:0]) * x) % longint'(mp[31:0]) == 1) mres = 256'(x);
                    end else begin
                        for (int j = 0; j < WORDS; j++) mres[32*j +: 32] = 32'h11111111 * (j + 1);
                    end
                    ka = 0; kp = 0; kb = 0;
                    if (cfg_never_rdy) mstate = 3;
                    else if (cfg_delay == 0) begin core_rdy = 1; core_flag = cfg_flag; mstate = 2; end
                    else begin mdelay = cfg_delay - 1; mstate = 1; end
                end else if (mstate == 1) begin
                    if (mdelay == 0) begin core_rdy = 1; core_flag = cfg_flag; mstate = 2; end
                    else mdelay--;
                end else if (mstate == 3) begin
                    if (!busy) mstate = 0;
                end
                if (mstate == 2 && core_out_ready) begin
                    core_rdy = 0; core_flag = 0; mstate = 4;
                    mj = 0; prev_ready = 0; gap3 = 0; gap7 = 0; extra = 0;
                end
                if (mstate == 4) begin
                    if (core_out_valid && prev_ready) begin
                        mj++;
                        if (mj == WORDS) check("out_ready_drop", core_out_ready, 0);
                    end
                    if (mj >= WORDS) begin
                        if (cfg_gaps && extra < 2) begin
                            core_out_valid = 1; core_result = 32'hDEADBEEF; extra++;
                        end else begin
                            core_out_valid = 0; mstate = 0;
                        end
                    end else if (cfg_gaps && mj == 3 && !gap3) begin
                        core_out_valid = 0; gap3 = 1;
                    end else if (cfg_gaps && mj == 7 && !gap7) begin
                        core_out_valid = 0; gap7 = 1;
                    end else begin
                        core_out_valid = 1; core_result = mres[32*mj +: 32];
                    end
                    prev_ready = core_out_ready;
                end
            end
        end
    end

    // Response monitor: every handshake pops one expected response.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", rsp_result, e.result);
                    check("rsp_flag", rsp_flag, e.flag);
                    check("rsp_timeout", rsp_timeout, e.timeout);
                    rsp_count++;
                end
            end
        end
    end

    // Drives a request now and returns once it has been accepted.
    task automatic issue(input logic mode, input logic [255:0] a, input logic [255:0] b,
                         input logic [255:0] p, output int waited);
        req_valid = 1; req_mode = mode; req_a = a; req_b = b; req_p = p;
        waited = 0;
        while (waited < 200) begin
            @(negedge clk);
            waited++;
            if (req_ready) break;
        end
        @(posedge clk);
        #1;
        req_valid = 0;
    endtask

    task automatic check_loads(input logic mode, input logic [255:0] a, input logic [255:0] b,
                               input logic [255:0] p);
        for (int c = 1; c <= 26; c++) begin
            logic [3:0]  es;
            logic [31:0] ed;
            @(negedge clk);
            if (c <= 8) begin es = 4'b1000; ed = a[32*(c-1) +: 32]; end
            else if (c <= 16) begin es = 4'b0100; ed = p[32*(c-9) +: 32]; end
            else if (c <= 24) begin es = 4'b0010; ed = b[32*(c-17) +: 32]; end
            else if (c == 25) begin es = 4'b0001; ed = 32'd0; end
            else begin es = 4'b0000; ed = 32'd0; end
            seen_data[c] = core_datain;
            check($sformatf("load_c%0d", c),
                  {core_loada, core_loadp, core_loadb, core_en, core_minv_mdiv, core_datain},
                  {es, mode, ed});
        end
    endtask

    task automatic wait_done(input logic mode, input string tag);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (busy && core_minv_mdiv !== mode) bad++;
            if (!busy) break;
        end
        check({tag, "_done"}, busy, 0);
        check({tag, "_mode_hold"}, bad, 0);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int w, n, bad, strobes;
        logic [255:0] hold_r;
        logic hold_f;
        rst = 1; req_valid = 0; req_mode = 0; req_a = '0; req_b = '0; req_p = '0; rsp_ready = 1;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {req_ready, busy, rsp_valid, rsp_flag, rsp_timeout, core_loada, core_loadp,
               core_loadb, core_en, core_minv_mdiv, core_out_ready, core_datain},
              {1'b1, 42'd0});
        check("reset_result", rsp_result, 0);
        @(posedge clk); #1; rst = 0;

        // serialisation of the SM2 operands, mode 0
        @(posedge clk); #1;
        cfg_delay = 3; cfg_flag = 1; cfg_gaps = 0;
        exp_q.push_back(mk(R_SCRIPT, 1'b1, 1'b0));
        issue(1'b0, SM2_A, SM2_B, SM2_P, w);
        check_loads(1'b0, SM2_A, SM2_B, SM2_P);
        check("ser_a0", seen_data[1], 32'h334C74C7);
        check("ser_a1", seen_data[2], 32'h715A4589);
        check("ser_a7", seen_data[8], 32'h32C4AE2C);
        check("ser_p0", seen_data[9], 32'hFFFFFFFF);
        check("ser_p2", seen_data[11], 32'h00000000);
        check("ser_p7", seen_data[16], 32'hFFFFFFFE);
        check("ser_b0", seen_data[17], 32'h2139F0A0);
        wait_done(1'b0, "ser");

        // inverse 5^-1 mod 11 = 9, core ready already high when WAIT is entered
        @(posedge clk); #1;
        cfg_delay = 0; cfg_flag = 0;
        exp_q.push_back(mk(256'd9, 1'b0, 1'b0));
        issue(1'b1, 256'd5, 256'd0, 256'd11, w);
        check_loads(1'b1, 256'd5, 256'd0, 256'd11);
        wait_done(1'b1, "inv");
        check("inv_core_a", cap_a, 256'd5);
        check("inv_core_p", cap_p, 256'd11);

        // gapped unload with trailing spurious words
        @(posedge clk); #1;
        cfg_delay = 3; cfg_flag = 1; cfg_gaps = 1;
        exp_q.push_back(mk(R_SCRIPT, 1'b1, 1'b0));
        issue(1'b0, SM2_A, SM2_B, SM2_P, w);
        wait_done(1'b0, "gap");

        // timeout: core never completes
        @(posedge clk); #1;
        cfg_gaps = 0; cfg_never_rdy = 1;
        exp_q.push_back(mk(256'd0, 1'b0, 1'b1));
        issue(1'b0, SM2_A, SM2_B, SM2_P, w);
        n = 0;
        while (n < 100 && !core_en) begin @(negedge clk); n++; end
        check("tmo_start_seen", core_en, 1);
        n = 0;
        while (n < 200 && !rsp_valid) begin @(negedge clk); n++; end
        // START cycle, then 64 WAIT cycles, then RESP on the 65th sample
        check("tmo_latency", n, 65);
        wait_done(1'b0, "tmo");
        @(posedge clk); #1; cfg_never_rdy = 0;

        // backpressure then back-to-back job
        @(posedge clk); #1;
        rsp_ready = 0; cfg_flag = 1;
        exp_q.push_back(mk(R_SCRIPT, 1'b1, 1'b0));
        issue(1'b0, SM2_A, SM2_B, SM2_P, w);
        n = 0;
        while (n < 200 && !rsp_valid) begin @(negedge clk); n++; end
        check("bp_rsp_seen", rsp_valid, 1);
        hold_r = rsp_result;
        hold_f = rsp_flag;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_result !== hold_r || rsp_flag !== hold_f) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_value", hold_r, R_SCRIPT);
        @(posedge clk); #1;
        rsp_ready = 1;
        exp_q.push_back(mk(R_SCRIPT, 1'b1, 1'b0));
        issue(1'b0, SM2_A, SM2_B, SM2_P, w);
        // one sample still in RESP, the next already IDLE: accept on the edge after handshake
        check("b2b_accept_wait", w, 2);
        check_loads(1'b0, SM2_A, SM2_B, SM2_P);
        wait_done(1'b0, "b2b");

        // reset during LOAD_P word 3
        @(posedge clk); #1;
        issue(1'b0, SM2_A, SM2_B, SM2_P, w);
        repeat (12) @(negedge clk);
        check("rst_at_p3", {core_loadp, core_datain}, {1'b1, SM2_P[127:96]});
        #2 rst = 1;
        #1;
        check("rst_async",
              {core_loada, core_loadp, core_loadb, core_en, core_datain, req_ready, busy},
              {36'd0, 1'b1, 1'b0});
        repeat (2) @(posedge clk);
        #1 rst = 0;
        bad = 0;
        strobes = 0;
        repeat (60) begin
            @(negedge clk);
            if (rsp_valid) bad++;
            if (core_loada || core_loadp || core_loadb || core_en) strobes++;
        end
        check("rst_no_rsp", bad, 0);
        check("rst_no_strobes", strobes, 0);
        check("rst_idle", {req_ready, busy}, 2'b10);

        check("sb_drained", exp_q.size(), 0);
        check("rsp_count", rsp_count, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/minv_mdiv_host.md
Name: minv_mdiv_host

Overview:
- Host-side initiator for the modular inverse/division core: the end of the core's word-load and result-unload protocol that drives it.
- Accepts one 256-bit job (a, b, p, mode) over a valid/ready request port.
- Serialises operands into the core's 32-bit load protocol and pulses the start strobe.
- Waits for completion, collects the 8-word result, and returns it as one 256-bit response with status flags.

Parameters:
- WORDS, 8, 32-bit words per operand/result (operand width = 32*WORDS).
- TIMEOUT_CYCLES, 16384, max cycles in WAIT or COLLECT before the job is aborted.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  job request valid.
- req_ready  out  1  high only in IDLE.
- req_mode  in  1  1 = modular inverse a^-1 mod p; 0 = modular division b/a mod p.
- req_a / req_b / req_p  in  256 each  operands.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_result  out  256  assembled result.
- rsp_flag  out  1  core minv_mdiv_flag, captured at completion.
- rsp_timeout  out  1  job aborted by timeout.
- busy  out  1  state != IDLE.
- core_datain  out  32  word to core.
- core_loada / core_loadp / core_loadb  out  1 each  load strobes.
- core_minv_mdiv  out  1  mode to core.
- core_en  out  1  start pulse.
- core_rdy  in  1  core done.
- core_flag  in  1  core status flag.
- core_result  in  32  result word.
- core_out_valid  in  1  result word valid.
- core_out_ready  out  1  host ready for result words.

Behaviour:
- Reset: state IDLE; every output is 0 except req_ready=1; the operand/result registers are cleared.
- A reset mid-job aborts immediately. The core gets no further strobes and no response is issued.
- Accept: on a clock edge with req_valid & req_ready, latch a, b, p and mode.
  - core_minv_mdiv = mode from the accept edge until the job returns to IDLE.
- LOAD_A, LOAD_P, LOAD_B (in that order): WORDS cycles each.
  - Only that phase's strobe is high.
  - core_datain = word k (LSW first, bits [32k+31:32k]) in phase cycle k.
  - The strobes never overlap and are never gapped. All 24 words go out on consecutive cycles, starting the cycle after accept.
  - b is loaded in both modes; the core ignores it when mode = 1.
- START: one cycle with core_en=1 and all strobes/data 0. Go to WAIT.
- WAIT: the timeout counter resets on entry.
  - On an edge where core_rdy=1, capture core_flag and go to COLLECT.
  - If the counter reaches TIMEOUT_CYCLES first, go to RESP with rsp_timeout=1 and rsp_result=0.
- COLLECT: core_out_ready is held high.
  - Each edge with core_out_valid=1 stores core_result into word index w (LSW first) and increments w.
  - Cycles with core_out_valid=0 hold w.
  - After word WORDS-1 is stored, core_out_ready drops on the next cycle and the state goes to RESP. Further core_out_valid is ignored.
  - The timeout counter restarts on entry. On timeout, go to RESP with rsp_timeout=1; words already collected are kept and the rest are 0.
- RESP: rsp_valid=1 with rsp_result, rsp_flag and rsp_timeout stable.
  - On rsp_valid & rsp_ready go to IDLE; rsp_valid drops the next cycle.
  - req_ready returns the same cycle as IDLE. A new request can be accepted on the edge after the response handshake.
- core_rdy seen outside WAIT is ignored. A core_rdy that is already high on WAIT entry completes WAIT on the first edge.
- Counter width covers TIMEOUT_CYCLES; it saturates and does not wrap.

Test Plan:
- Serialisation check.
  - Stimulus: mode=0, SM2 p=FFFFFFFE_FFFFFFFF_..._00000000_FFFFFFFF_FFFFFFFF, a=32C4AE2C_..._334C74C7, b=BC3736A2_..._2139F0A0.
  - Required: cycles 1–8 after accept show loada with datain 334C74C7, 715A4589, …, 32C4AE2C. Cycles 9–16 show loadp with FFFFFFFF … FFFFFFFE. Cycles 17–24 show loadb. Cycle 25 shows core_en=1 for exactly one cycle.
- Inverse with a behavioural core model: a=5, p=11, mode=1 -> core_minv_mdiv=1 throughout; rsp_result=9, rsp_flag=0, rsp_timeout=0.
- Gapped unload: the model inserts core_out_valid=0 bubbles between words 2/3 and 6/7 -> all 8 words are assembled in order; core_out_ready is low the cycle after the 8th word.
- Timeout: the model never raises core_rdy, TIMEOUT_CYCLES=64 -> rsp_valid appears 64 cycles after entering WAIT with rsp_timeout=1 and rsp_result=0.
- Backpressure and back-to-back: hold rsp_ready=0 for 10 cycles -> response held stable. Then a second job (mode=0, same operands) is accepted on the edge after the handshake and produces the same load sequence.
- Reset mid-job: assert rst during LOAD_P word 3 -> all strobes drop asynchronously, req_ready=1, and no rsp_valid is issued.
